shreg_seq_ctrl: RTL and testbench

Sequencing controller and two-requester arbiter for the 8-bit loadable shift register datapath (load / shift-left / shift-right / hold, with serial-in).
- Accepts byte jobs from two requesters, round-robin.
- Drives the datapath through load, then SHIFT_CNT shift cycles.
- Returns the resulting register value, tagged with requester id, over a valid/ready response port.
- Sits between the bus-side requesters and the shift register datapath.

---
 rtl/shreg_seq_pkg.sv | 26 ++
 rtl/shreg_seq_ctrl_if.sv | 35 +++
 rtl/shreg_rr_arb2.sv | 35 +++
 rtl/shreg_seq_ctrl.sv | 126 ++++++++++++
 tb/tb_shreg_seq_ctrl.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/shreg_seq_pkg.sv
// Shared types for the shift-register sequencing controller: FSM states,
// datapath mode encodings and shift-direction values.
package shreg_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHL  = 2'b01,
    MODE_SHR  = 2'b10,
    MODE_LOAD = 2'b11
  } dp_mode_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  function automatic dp_mode_e shift_mode(input logic dir);
    return (dir == DIR_RIGHT) ? MODE_SHR : MODE_SHL;
  endfunction

endpackage

// File: rtl/shreg_seq_ctrl_if.sv
// Bus bundle between requesters, the sequencing controller and the shift
// register datapath. The controller uses the slave view.
interface shreg_seq_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [WIDTH-1:0] req0_data;
  logic             req0_dir;
  logic             req0_fill;
  logic [WIDTH-1:0] req1_data;
  logic             req1_dir;
  logic             req1_fill;
  logic [1:0]       dp_mode;
  logic [WIDTH-1:0] dp_din;
  logic             dp_sin;
  logic [WIDTH-1:0] dp_q;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_id;
  logic             busy;

  modport slave (
    input  req_valid, req0_data, req0_dir, req0_fill,
           req1_data, req1_dir, req1_fill, dp_q, rsp_ready,
    output req_ready, dp_mode, dp_din, dp_sin, rsp_valid, rsp_data, rsp_id, busy
  );

  modport master (
    output req_valid, req0_data, req0_dir, req0_fill,
           req1_data, req1_dir, req1_fill, dp_q, rsp_ready,
    input  req_ready, dp_mode, dp_din, dp_sin, rsp_valid, rsp_data, rsp_id, busy
  );
endinterface

// File: rtl/shreg_rr_arb2.sv
// Two-requester round-robin grant; the priority bit flips to the other
// requester whenever a grant is taken.
module shreg_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  input  logic       take,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  logic prio_q, prio_d;

  always_comb begin
    gnt_id = 1'b0;
    gnt    = '0;
    if (en) begin
      case (req)
        2'b01:   begin gnt_id = 1'b0;   gnt = 2'b01; end
        2'b10:   begin gnt_id = 1'b1;   gnt = 2'b10; end
        2'b11:   begin gnt_id = prio_q; gnt = prio_q ? 2'b10 : 2'b01; end
        default: begin gnt_id = 1'b0;   gnt = '0;    end
      endcase
    end
    prio_d = prio_q;
    if (take) prio_d = ~gnt_id;
  end

  always_ff @(posedge clk) begin
    if (rst) prio_q <= 1'b0;
    else     prio_q <= prio_d;
  end

endmodule

// File: rtl/shreg_seq_ctrl.sv
// Sequencing controller: arbitrates byte jobs, loads the shift register,
// shifts it SHIFT_CNT times and returns the result. Define
// SHREG_SEQ_ROTATE_EN to feed the outgoing bit back as serial-in (rotate).
module shreg_seq_ctrl
  import shreg_seq_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned SHIFT_CNT = 8,
  parameter int unsigned CNT_W     = 4
) (
  input logic             clk,
  input logic             rst,
  shreg_seq_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SHIFT_CNT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             dir_q, dir_d;
  logic             fill_q, fill_d;
  logic             id_q, id_d;

  logic       arb_en;
  logic [1:0] grant;
  logic       grant_id;
  logic       accept;

  dp_mode_e         mode;
  logic [WIDTH-1:0] din;
  logic             sin;
  logic             rsp_valid;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_id;

  assign arb_en = (state_q == ST_IDLE);
  assign accept = |(bus.req_valid & grant);

  shreg_rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (bus.req_valid),
    .en     (arb_en),
    .take   (accept),
    .gnt    (grant),
    .gnt_id (grant_id)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    dir_d     = dir_q;
    fill_d    = fill_q;
    id_d      = id_q;
    mode      = MODE_HOLD;
    din       = '0;
    sin       = 1'b0;
    rsp_valid = 1'b0;
    rsp_data  = '0;
    rsp_id    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          data_d  = grant_id ? bus.req1_data : bus.req0_data;
          dir_d   = grant_id ? bus.req1_dir  : bus.req0_dir;
          fill_d  = grant_id ? bus.req1_fill : bus.req0_fill;
          id_d    = grant_id;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        mode    = MODE_LOAD;
        din     = data_q;
        cnt_d   = '0;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        mode = shift_mode(dir_q);
`ifdef SHREG_SEQ_ROTATE_EN
        sin = (dir_q == DIR_RIGHT) ? bus.dp_q[0] : bus.dp_q[WIDTH-1];
`else
        sin = fill_q;
`endif
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = ST_DONE;
      end
      ST_DONE: begin
        rsp_valid = 1'b1;
        rsp_data  = bus.dp_q;
        rsp_id    = id_q;
        if (bus.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      dir_q   <= 1'b0;
      fill_q  <= 1'b0;
      id_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      dir_q   <= dir_d;
      fill_q  <= fill_d;
      id_q    <= id_d;
    end
  end

  assign bus.req_ready = grant;
  assign bus.dp_mode   = mode;
  assign bus.dp_din    = din;
  assign bus.dp_sin    = sin;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data  = rsp_data;
  assign bus.rsp_id    = rsp_id;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_shreg_seq_ctrl.sv
// Bench for shreg_seq_ctrl: directed job table, multi-cycle corner cases and
// a randomized phase checked against a job-level reference model.
module tb_shreg_seq_ctrl;

  localparam int unsigned W  = 8;
  localparam int unsigned SC = 8;
  localparam int unsigned CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  shreg_seq_ctrl_if #(.WIDTH(W)) bus ();

  shreg_seq_ctrl #(.WIDTH(W), .SHIFT_CNT(SC), .CNT_W(CW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // External shift-register datapath driven by the controller
  always @(posedge clk) begin
    if (rst) bus.dp_q <= '0;
    else begin
      case (bus.dp_mode)
        2'b01:   bus.dp_q <= {bus.dp_q[W-2:0], bus.dp_sin};
        2'b10:   bus.dp_q <= {bus.dp_sin, bus.dp_q[W-1:1]};
        2'b11:   bus.dp_q <= bus.dp_din;
        default: bus.dp_q <= bus.dp_q;
      endcase
    end
  end

  // Job result from the shift rules, in plain arithmetic
  function automatic logic [W-1:0] exp_result(input logic [W-1:0] d, input logic dir,
                                              input logic fill);
    int unsigned v, full, ones, r;
    v    = 32'(d);
    full = (32'd1 << W) - 1;
    ones = (32'd1 << SC) - 1;
`ifdef SHREG_SEQ_ROTATE_EN
    if (fill) r = 0;
    if (!dir) r = ((v << SC) | (v >> (W - SC))) & full;
    else      r = ((v >> SC) | (v << (W - SC))) & full;
`else
    if (!dir) r = ((v << SC) | (fill ? ones : 0)) & full;
    else      r = (v >> SC) | (fill ? ((ones << (W - SC)) & full) : 0);
`endif
    return W'(r);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_req(input logic id, input logic [W-1:0] d, input logic dir, input logic fill);
    if (!id) begin bus.req0_data = d; bus.req0_dir = dir; bus.req0_fill = fill; end
    else     begin bus.req1_data = d; bus.req1_dir = dir; bus.req1_fill = fill; end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_dp_mode"},   32'(bus.dp_mode), 0);
    check({tag, "_dp_din"},    32'(bus.dp_din), 0);
    check({tag, "_dp_sin"},    32'(bus.dp_sin), 0);
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 0);
    check({tag, "_rsp_data"},  32'(bus.rsp_data), 0);
    check({tag, "_rsp_id"},    32'(bus.rsp_id), 0);
    check({tag, "_busy"},      32'(bus.busy), 0);
  endtask

  // Issues one job from the requesters in vmask (held for the whole job) and
  // returns on the cycle the response first shows up.
  task automatic run_job(input string tag, input logic [1:0] vmask, input logic rdy,
                         input logic exp_id, input logic [W-1:0] exp_din,
                         input logic exp_dir, input logic [W-1:0] exp_q);
    int cyc, nsh;
    @(negedge clk);
    bus.req_valid = vmask;
    bus.rsp_ready = rdy;
    #1;
    check({tag, "_grant"}, 32'(bus.req_ready), 32'(2'b01 << exp_id));
    @(negedge clk);
    cyc = 1;
    set_req(exp_id, W'($urandom), 1'($urandom), 1'($urandom));
    check({tag, "_load_mode"}, 32'(bus.dp_mode), 3);
    check({tag, "_load_din"},  32'(bus.dp_din), 32'(exp_din));
    nsh = 0;
    while (!bus.rsp_valid && cyc < 64) begin
      if (bus.dp_mode == (exp_dir ? 2'b10 : 2'b01)) nsh++;
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"},  32'(cyc), SC + 2);
    check({tag, "_shifts"},   32'(nsh), SC);
    check({tag, "_rsp_data"}, 32'(bus.rsp_data), 32'(exp_q));
    check({tag, "_rsp_id"},   32'(bus.rsp_id), 32'(exp_id));
    check({tag, "_hold"},     32'(bus.dp_mode), 0);
  endtask

  typedef struct {
    logic         id;
    logic [W-1:0] data;
    logic         dir;
    logic         fill;
    logic [W-1:0] exp_q;
  } vec_t;

  vec_t vecs[4];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "simulation time limit");
  end

  initial begin : main
    logic [W-1:0] d0, d1, hold_data;
    logic         r0, r1, f0, f1, saw_rsp;
    logic         prefer_m, idle_m, pending, seen, gid;
    logic [1:0]   eg;
    logic [W-1:0] exp_d;
    logic         exp_id;
    int           elapsed;

`ifdef SHREG_SEQ_ROTATE_EN
    vecs[0] = '{1'b0, 8'hA5, 1'b0, 1'b0, 8'hA5};
    vecs[1] = '{1'b1, 8'hA5, 1'b1, 1'b1, 8'hA5};
    vecs[2] = '{1'b0, 8'h3C, 1'b0, 1'b1, 8'h3C};
    vecs[3] = '{1'b1, 8'h81, 1'b1, 1'b0, 8'h81};
`else
    vecs[0] = '{1'b0, 8'hA5, 1'b0, 1'b0, 8'h00};
    vecs[1] = '{1'b1, 8'hA5, 1'b1, 1'b1, 8'hFF};
    vecs[2] = '{1'b0, 8'h3C, 1'b0, 1'b1, 8'hFF};
    vecs[3] = '{1'b1, 8'h81, 1'b1, 1'b0, 8'h00};
`endif

    set_req(1'b0, '0, 1'b0, 1'b0);
    set_req(1'b1, '0, 1'b0, 1'b0);
    do_reset();
    #1;
    check_idle_outputs("reset");
    check("reset_req_ready", 32'(bus.req_ready), 0);

    for (int i = 0; i < 4; i++) begin
      set_req(vecs[i].id, vecs[i].data, vecs[i].dir, vecs[i].fill);
      run_job($sformatf("vec%0d", i), 2'b01 << vecs[i].id, 1'b1, vecs[i].id,
              vecs[i].data, vecs[i].dir, vecs[i].exp_q);
    end

    // Both requesters valid throughout: grants alternate starting at 0
    do_reset();
    for (int k = 0; k < 4; k++) begin
      d0 = W'($urandom); r0 = 1'($urandom); f0 = 1'($urandom);
      d1 = W'($urandom); r1 = 1'($urandom); f1 = 1'($urandom);
      set_req(1'b0, d0, r0, f0);
      set_req(1'b1, d1, r1, f1);
      if (k % 2 == 0) run_job($sformatf("arb%0d", k), 2'b11, 1'b1, 1'b0, d0, r0, exp_result(d0, r0, f0));
      else            run_job($sformatf("arb%0d", k), 2'b11, 1'b1, 1'b1, d1, r1, exp_result(d1, r1, f1));
    end

    // Response backpressure for 5 cycles in DONE
    set_req(1'b0, 8'hA5, 1'b0, 1'b0);
    run_job("bp", 2'b01, 1'b0, 1'b0, 8'hA5, 1'b0, exp_result(8'hA5, 1'b0, 1'b0));
    hold_data = exp_result(8'hA5, 1'b0, 1'b0);
    bus.req_valid = 2'b11;
    #1;
    for (int k = 0; k < 5; k++) begin
      check("bp_rsp_valid", 32'(bus.rsp_valid), 1);
      check("bp_rsp_data",  32'(bus.rsp_data), 32'(hold_data));
      check("bp_dp_mode",   32'(bus.dp_mode), 0);
      check("bp_req_ready", 32'(bus.req_ready), 0);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    bus.req_valid = '0;
    @(negedge clk);
    check("bp_release_busy", 32'(bus.busy), 0);
    check("bp_release_rsp_valid", 32'(bus.rsp_valid), 0);

    // Reset on the 3rd shift cycle of a requester-0 job
    @(negedge clk);
    set_req(1'b0, 8'h5A, 1'b1, 1'b1);
    bus.req_valid = 2'b01;
    #1;
    check("mid_grant", 32'(bus.req_ready), 1);
    @(negedge clk);
    bus.req_valid = '0;
    repeat (3) @(negedge clk);
    check("mid_shifting", 32'(bus.dp_mode), 2);
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("mid_rst");
    rst = 1'b0;
    saw_rsp = 1'b0;
    repeat (14) begin
      @(negedge clk);
      saw_rsp = saw_rsp | bus.rsp_valid | bus.busy;
    end
    check("mid_no_rsp", 32'(saw_rsp), 0);
    d0 = 8'hC3; d1 = 8'h17;
    set_req(1'b0, d0, 1'b1, 1'b0);
    set_req(1'b1, d1, 1'b0, 1'b1);
    run_job("post_rst", 2'b11, 1'b1, 1'b0, d0, 1'b1, exp_result(d0, 1'b1, 1'b0));

    // Randomized traffic against the job-level model
    do_reset();
    prefer_m = 1'b0; idle_m = 1'b1; pending = 1'b0; seen = 1'b0;
    exp_d = '0; exp_id = 1'b0; elapsed = 0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      bus.req_valid = 2'($urandom);
      set_req(1'b0, W'($urandom), 1'($urandom), 1'($urandom));
      set_req(1'b1, W'($urandom), 1'($urandom), 1'($urandom));
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      eg = '0;
      if (idle_m) begin
        if (bus.req_valid == 2'b01)      eg = 2'b01;
        else if (bus.req_valid == 2'b10) eg = 2'b10;
        else if (bus.req_valid == 2'b11) eg = prefer_m ? 2'b10 : 2'b01;
      end
      check("rnd_req_ready", 32'(bus.req_ready), 32'(eg));
      check("rnd_busy", 32'(bus.busy), 32'(!idle_m));
      if (pending) elapsed++;
      if (pending && !seen && (bus.rsp_valid || elapsed == SC + 2)) begin
        check("rnd_latency", 32'(elapsed), SC + 2);
        check("rnd_rsp_on_time", 32'(bus.rsp_valid), 1);
        seen = 1'b1;
      end
      if (bus.rsp_valid) begin
        check("rnd_rsp_expected", 32'(bus.rsp_valid), 32'(pending));
        if (pending) begin
          check("rnd_rsp_data", 32'(bus.rsp_data), 32'(exp_d));
          check("rnd_rsp_id",   32'(bus.rsp_id), 32'(exp_id));
          if (bus.rsp_ready) begin
            pending = 1'b0;
            idle_m  = 1'b1;
          end
        end
      end else if (!pending) begin
        check("rnd_rsp_idle_data", 32'(bus.rsp_data), 0);
      end
      if (eg != 2'b00) begin
        gid      = eg[1];
        exp_d    = gid ? exp_result(bus.req1_data, bus.req1_dir, bus.req1_fill)
                       : exp_result(bus.req0_data, bus.req0_dir, bus.req0_fill);
        exp_id   = gid;
        prefer_m = ~gid;
        idle_m   = 1'b0;
        pending  = 1'b1;
        seen     = 1'b0;
        elapsed  = 0;
      end
    end

    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 40 && bus.busy; k++) @(negedge clk);
    check("drain_busy", 32'(bus.busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
